// File: rtl/alu.sv
// alu: 32-bit integer ALU for the execute stage.
// The result and the Zero/Neg/ovfalu flags are registered, so results appear
// one clock after the operands.
// Optional feature: define ALU_SHIFT_EN to build the sll/srl/sra shifter.
// When it is not defined, af 1000/1001/1100 decode like the unused codes and
// produce 0.
module alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic [3:0]  af,
    input  logic        i,
    output logic [31:0] Alures,
    output logic        Zero,
    output logic        Neg,
    output logic        ovfalu
);

    logic [31:0] sum_next;
    logic [31:0] diff_next;
    logic        slt_next;
    logic        sltu_next;
    logic [31:0] res_next;
    logic        ovf_next;

    logic [31:0] alures_reg;
    logic        zero_reg;
    logic        neg_reg;
    logic        ovf_reg;

    assign sum_next  = SrcA + SrcB;
    assign diff_next = SrcA - SrcB;
    // Compare on the full operands so a wrapped difference cannot flip the answer
    assign slt_next  = ($signed(SrcA) < $signed(SrcB));
    assign sltu_next = (SrcA < SrcB);

`ifdef ALU_SHIFT_EN
    // One right-shifting log shifter serves all three shifts. A left shift is
    // done by bit-reversing the operand on the way in and on the way out.
    // The fill bit is the sign bit only for sra.
    logic        shift_left;
    logic        shift_fill;
    logic [31:0] shift_in;
    logic [31:0] shift_stage [0:5];
    logic [31:0] shift_out;

    assign shift_left = (af == 4'b1000);
    assign shift_fill = (af == 4'b1100) & SrcB[31];

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_rev_in
            assign shift_in[gi] = shift_left ? SrcB[31-gi] : SrcB[gi];
        end
    endgenerate

    assign shift_stage[0] = shift_in;

    generate
        for (gi = 0; gi < 5; gi++) begin : g_stage
            localparam int SH = 1 << gi;
            assign shift_stage[gi+1] = SrcA[gi]
                ? {{SH{shift_fill}}, shift_stage[gi][31:SH]}
                : shift_stage[gi];
        end
    endgenerate

    generate
        for (gi = 0; gi < 32; gi++) begin : g_rev_out
            assign shift_out[gi] = shift_left ? shift_stage[5][31-gi] : shift_stage[5][gi];
        end
    endgenerate
`endif

    // Decode the function code into the next result and the signed-overflow flag
    always_comb begin
        res_next = 32'h0;
        ovf_next = 1'b0;
        case (af)
            4'b0000: begin
                res_next = sum_next;
                ovf_next = (SrcA[31] == SrcB[31]) && (sum_next[31] != SrcA[31]);
            end
            4'b0001: res_next = sum_next;
            4'b0010: begin
                res_next = diff_next;
                ovf_next = (SrcA[31] != SrcB[31]) && (diff_next[31] != SrcA[31]);
            end
            4'b0011: res_next = diff_next;
            4'b0100: res_next = SrcA & SrcB;
            4'b0101: res_next = SrcA | SrcB;
            4'b0110: res_next = SrcA ^ SrcB;
            4'b0111: res_next = i ? {SrcB[15:0], 16'h0} : ~(SrcA | SrcB);
            4'b1010: res_next = {31'b0, slt_next};
            4'b1011: res_next = {31'b0, sltu_next};
`ifdef ALU_SHIFT_EN
            4'b1000: res_next = shift_out;
            4'b1001: res_next = shift_out;
            4'b1100: res_next = shift_out;
`endif
            default: res_next = 32'h0;
        endcase
    end

    // Register the result and flags; a low rst_n clears all of them
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alures_reg <= 32'h0;
            zero_reg   <= 1'b0;
            neg_reg    <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            alures_reg <= res_next;
            zero_reg   <= (res_next == 32'h0);
            neg_reg    <= res_next[31];
            ovf_reg    <= ovf_next;
        end
    end

    assign Alures = alures_reg;
    assign Zero   = zero_reg;
    assign Neg    = neg_reg;
    assign ovfalu = ovf_reg;

endmodule

// File: tb/tb_alu.sv
// tb_alu: scoreboard bench for alu.
// Every transaction pushes its expected result and flags when it is driven.
// The bench pops and compares them one clock later.
module tb_alu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [3:0]  af;
    logic        i;
    logic [31:0] Alures;
    logic        Zero;
    logic        Neg;
    logic        ovfalu;

    always #5 clk = ~clk;

    alu dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .af     (af),
        .i      (i),
        .Alures (Alures),
        .Zero   (Zero),
        .Neg    (Neg),
        .ovfalu (ovfalu)
    );

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic [2:0]  flags;   // {Zero, Neg, ovfalu}
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Drive one transaction on the falling edge and queue what it must produce
    task automatic drive(input string tag, input logic rn, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] f, input logic ii,
                         input logic [31:0] er, input logic ez, input logic en,
                         input logic eo);
        exp_t e;
        @(negedge clk);
        rst_n = rn;
        SrcA  = a;
        SrcB  = b;
        af    = f;
        i     = ii;
        e.tag   = tag;
        e.res   = er;
        e.flags = {ez, en, eo};
        sb_q.push_back(e);
    endtask

    // Normal operation: Zero and Neg follow directly from the expected result
    task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] f, input logic ii, input logic [31:0] er,
                      input logic eo);
        drive(tag, 1'b1, a, b, f, ii, er, (er == 32'h0), er[31], eo);
    endtask

    // Reference behaviour used for the random sweep
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] f, input logic ii,
                                  output logic [31:0] r, output logic ov);
        r  = 32'h0;
        ov = 1'b0;
        case (f)
            4'h0: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
            4'h1: r = a + b;
            4'h2: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
            4'h3: r = a - b;
            4'h4: r = a & b;
            4'h5: r = a | b;
            4'h6: r = a ^ b;
            4'h7: r = ii ? (b << 16) : ~(a | b);
            4'hA: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'hB: r = (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_SHIFT_EN
            4'h8: r = b << a[4:0];
            4'h9: r = b >> a[4:0];
            4'hC: r = 32'($signed(b) >>> a[4:0]);
`endif
            default: r = 32'h0;
        endcase
    endfunction

    // Compare each queued expectation just after the edge that produced it
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                $display("txn %-10s res=%08h z=%0b n=%0b v=%0b", e.tag, Alures, Zero, Neg, ovfalu);
                check({e.tag, ".res"}, Alures, e.res);
                check({e.tag, ".flags"}, {29'b0, Zero, Neg, ovfalu}, {29'b0, e.flags});
            end
        end
    end

    initial begin
        logic [31:0] ra, rb, er;
        logic [3:0]  rf;
        logic        ri, eo;

        // Reset overrides live inputs
        drive("rst0", 1'b0, 32'd10, 32'd5, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        drive("rst1", 1'b0, 32'd10, 32'd5, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        op("rel_add", 32'd10, 32'd5, 4'h0, 1'b0, 32'd15, 1'b0);

        // Arithmetic
        op("addu",    32'd20, 32'd15, 4'h1, 1'b0, 32'd35, 1'b0);
        op("sub_neg", 32'd25, 32'd30, 4'h2, 1'b0, 32'hFFFFFFFB, 1'b0);
        op("subu",    32'd30, 32'd10, 4'h3, 1'b0, 32'd20, 1'b0);
        op("add_i1",  32'd1,  32'd2,  4'h0, 1'b1, 32'd3, 1'b0);

        // Logic
        op("and", 32'hFF00FF00, 32'h0F0F0F0F, 4'h4, 1'b0, 32'h0F000F00, 1'b0);
        op("or",  32'hFF00FF00, 32'h0F0F0F0F, 4'h5, 1'b0, 32'hFF0FFF0F, 1'b0);
        op("xor", 32'hFFFF0000, 32'h0000FFFF, 4'h6, 1'b0, 32'hFFFFFFFF, 1'b0);
        op("lui", 32'hAAAAAAAA, 32'h00001234, 4'h7, 1'b1, 32'h12340000, 1'b0);
        op("nor", 32'hFF00FF00, 32'h0F0F0F0F, 4'h7, 1'b0, 32'h00F000F0, 1'b0);

        // Compare
        op("slt",      32'hFFFFFFFB, 32'd3, 4'hA, 1'b0, 32'd1, 1'b0);
        op("sltu",     32'd2,        32'd3, 4'hB, 1'b0, 32'd1, 1'b0);
        op("sltu_big", 32'hFFFFFFFB, 32'd3, 4'hB, 1'b0, 32'd0, 1'b0);
        op("slt_eq",   32'd9,        32'd9, 4'hA, 1'b0, 32'd0, 1'b0);
        op("slt_wrap", 32'h80000000, 32'd1, 4'hA, 1'b0, 32'd1, 1'b0);
        op("sub_zero", 32'd7,        32'd7, 4'h2, 1'b0, 32'd0, 1'b0);

        // Overflow
        op("add_ovf",  32'h7FFFFFFF, 32'd1, 4'h0, 1'b0, 32'h80000000, 1'b1);
        op("addu_ovf", 32'h7FFFFFFF, 32'd1, 4'h1, 1'b0, 32'h80000000, 1'b0);
        op("sub_ovf",  32'h80000000, 32'd1, 4'h2, 1'b0, 32'h7FFFFFFF, 1'b1);
        op("subu_ovf", 32'h80000000, 32'd1, 4'h3, 1'b0, 32'h7FFFFFFF, 1'b0);

        // Unused codes
        op("unused_d", 32'hFFFFFFFF, 32'hFFFFFFFF, 4'hD, 1'b1, 32'h0, 1'b0);
        op("unused_f", 32'h12345678, 32'h9ABCDEF0, 4'hF, 1'b0, 32'h0, 1'b0);

        // Shifts
`ifdef ALU_SHIFT_EN
        op("sll",      32'd4,        32'd1,        4'h8, 1'b0, 32'h00000010, 1'b0);
        op("sra",      32'd4,        32'h80000000, 4'hC, 1'b0, 32'hF8000000, 1'b0);
        op("srl",      32'd4,        32'h80000000, 4'h9, 1'b0, 32'h08000000, 1'b0);
        op("sll_0",    32'd0,        32'hDEADBEEF, 4'h8, 1'b0, 32'hDEADBEEF, 1'b0);
        op("sll_hiA",  32'hFFFFFFE4, 32'd1,        4'h8, 1'b0, 32'h00000010, 1'b0);
        op("sra_31",   32'd31,       32'h80000000, 4'hC, 1'b0, 32'hFFFFFFFF, 1'b0);
        op("srl_31",   32'd31,       32'h80000000, 4'h9, 1'b0, 32'h00000001, 1'b0);
`else
        op("sll_off",  32'd4, 32'd1,        4'h8, 1'b0, 32'h0, 1'b0);
        op("srl_off",  32'd4, 32'h80000000, 4'h9, 1'b0, 32'h0, 1'b0);
        op("sra_off",  32'd4, 32'h80000000, 4'hC, 1'b0, 32'h0, 1'b0);
`endif

        // Random sweep over all codes at full throughput
        for (int k = 0; k < 40; k++) begin
            ra = $urandom();
            rb = $urandom();
            rf = 4'($urandom_range(0, 15));
            ri = 1'($urandom_range(0, 1));
            model(ra, rb, rf, ri, er, eo);
            op("rand", ra, rb, rf, ri, er, eo);
        end

        // Reset in the middle of traffic
        drive("rst_mid", 1'b0, 32'hFFFFFFFF, 32'h1, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        op("post_rst", 32'h7FFFFFFF, 32'd1, 4'h0, 1'b0, 32'h80000000, 1'b1);

        // Every queued expectation must have been consumed
        repeat (3) @(posedge clk);
        #2;
        check("drain", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
